// File: rtl/wordle_feedback.sv
// wordle_feedback: sequential Wordle-style colour evaluator for a 5-digit
// packed-BCD guess against a 5-digit packed-BCD secret.
// Colour codes: 00 miss, 01 present elsewhere, 10 correct position, 11 invalid.
// Optional build macro WORDLE_FAST_EVAL_EN: each SCAN cycle compares one guess
// digit against all five secret digits (5 SCAN cycles instead of 25).
module wordle_feedback #(
  parameter int DIGIT_W   = 4,
  parameter int MAX_DIGIT = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [5*DIGIT_W-1:0] secret,
  input  logic [5*DIGIT_W-1:0] guess,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           led0_in,
  output logic [1:0]           led1_in,
  output logic [1:0]           led2_in,
  output logic [1:0]           led3_in,
  output logic [1:0]           led4_in,
  output logic [2:0]           hit_count,
  output logic [2:0]           near_count,
  output logic                 all_hit
);

  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX_DIGIT);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t               state;
  logic [5*DIGIT_W-1:0] sec_r;
  logic [5*DIGIT_W-1:0] gue_r;
  logic [DIGIT_W-1:0]   sec_d [5];
  logic [DIGIT_W-1:0]   gue_d [5];
  logic [2:0]           g_idx;
`ifndef WORDLE_FAST_EVAL_EN
  logic [2:0]           s_idx;
`endif
  logic [1:0]           scratch      [5];
  logic [1:0]           next_scratch [5];
  logic                 last_cmp;
  logic [2:0]           hit_n;
  logic [2:0]           near_n;

  // Split the captured operands into per-digit fields for indexed access
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      sec_d[i] = sec_r[i*DIGIT_W +: DIGIT_W];
      gue_d[i] = gue_r[i*DIGIT_W +: DIGIT_W];
    end
  end

`ifdef WORDLE_FAST_EVAL_EN
  // Resolve the full code of guess digit g against all secret digits at once
  always_comb begin
    logic present;
    logic exact;
    present = 1'b0;
    exact   = (gue_d[g_idx] == sec_d[g_idx]);
    for (int s = 0; s < 5; s++) begin
      next_scratch[s] = scratch[s];
      if ((gue_d[g_idx] == sec_d[s]) && (s != int'(g_idx)))
        present = 1'b1;
    end
    if (gue_d[g_idx] > MAX_D)
      next_scratch[g_idx] = 2'b11;
    else if (exact)
      next_scratch[g_idx] = 2'b10;
    else if (present)
      next_scratch[g_idx] = 2'b01;
    else
      next_scratch[g_idx] = 2'b00;
    last_cmp = (g_idx == 3'd4);
  end
`else
  // Fold one (g,s) comparison into the scratch code; exact never downgrades to present
  always_comb begin
    for (int i = 0; i < 5; i++)
      next_scratch[i] = scratch[i];
    if (gue_d[g_idx] > MAX_D)
      next_scratch[g_idx] = 2'b11;
    else if (gue_d[g_idx] == sec_d[s_idx]) begin
      if (g_idx == s_idx)
        next_scratch[g_idx] = 2'b10;
      else if (scratch[g_idx] != 2'b10)
        next_scratch[g_idx] = 2'b01;
    end
    last_cmp = (g_idx == 3'd4) && (s_idx == 3'd4);
  end
`endif

  // Count hits and nears over the codes that will be published at the end of SCAN
  always_comb begin
    hit_n  = 3'd0;
    near_n = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (next_scratch[i] == 2'b10)
        hit_n = hit_n + 3'd1;
      if (next_scratch[i] == 2'b01)
        near_n = near_n + 3'd1;
    end
  end

  // Control FSM: capture on start, scan comparisons, publish results for one done cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      led0_in    <= 2'b00;
      led1_in    <= 2'b00;
      led2_in    <= 2'b00;
      led3_in    <= 2'b00;
      led4_in    <= 2'b00;
      hit_count  <= 3'd0;
      near_count <= 3'd0;
      all_hit    <= 1'b0;
      sec_r      <= '0;
      gue_r      <= '0;
      g_idx      <= 3'd0;
`ifndef WORDLE_FAST_EVAL_EN
      s_idx      <= 3'd0;
`endif
      for (int i = 0; i < 5; i++)
        scratch[i] <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sec_r <= secret;
            gue_r <= guess;
            g_idx <= 3'd0;
`ifndef WORDLE_FAST_EVAL_EN
            s_idx <= 3'd0;
`endif
            for (int i = 0; i < 5; i++)
              scratch[i] <= 2'b00;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          for (int i = 0; i < 5; i++)
            scratch[i] <= next_scratch[i];
`ifdef WORDLE_FAST_EVAL_EN
          g_idx <= g_idx + 3'd1;
`else
          if (s_idx == 3'd4) begin
            s_idx <= 3'd0;
            g_idx <= g_idx + 3'd1;
          end else begin
            s_idx <= s_idx + 3'd1;
          end
`endif
          if (last_cmp) begin
            led0_in    <= next_scratch[0];
            led1_in    <= next_scratch[1];
            led2_in    <= next_scratch[2];
            led3_in    <= next_scratch[3];
            led4_in    <= next_scratch[4];
            hit_count  <= hit_n;
            near_count <= near_n;
            all_hit    <= (hit_n == 3'd5);
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wordle_feedback.sv
// tb_wordle_feedback: directed scoreboard bench for wordle_feedback.
// Honours WORDLE_FAST_EVAL_EN for the expected done latency.
module tb_wordle_feedback;

`ifdef WORDLE_FAST_EVAL_EN
  localparam int LAT    = 6;
  localparam int RST_AT = 3;
`else
  localparam int LAT    = 26;
  localparam int RST_AT = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [19:0] secret = '0;
  logic [19:0] guess = '0;
  logic        busy;
  logic        done;
  logic [1:0]  led0_in, led1_in, led2_in, led3_in, led4_in;
  logic [2:0]  hit_count;
  logic [2:0]  near_count;
  logic        all_hit;

  typedef struct {
    string      tag;
    logic [9:0] leds;
    logic [2:0] hit;
    logic [2:0] near;
    logic       all;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  wordle_feedback dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .secret     (secret),
    .guess      (guess),
    .busy       (busy),
    .done       (done),
    .led0_in    (led0_in),
    .led1_in    (led1_in),
    .led2_in    (led2_in),
    .led3_in    (led3_in),
    .led4_in    (led4_in),
    .hit_count  (hit_count),
    .near_count (near_count),
    .all_hit    (all_hit)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [9:0] ledsNow();
    return {led4_in, led3_in, led2_in, led1_in, led0_in};
  endfunction

  task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one evaluation request and record what it must produce
  task automatic applyStimulus(string tag, logic [19:0] sec, logic [19:0] gue,
                               logic [9:0] leds, logic [2:0] hit, logic [2:0] near);
    exp_t e;
    e.tag  = tag;
    e.leds = leds;
    e.hit  = hit;
    e.near = near;
    e.all  = (hit == 3'd5);
    sb.push_back(e);
    @(negedge clk);
    secret = sec;
    guess  = gue;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Pop the oldest expectation and compare it to the published results
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checkVal("sb_underflow", 32'(sb.size()), 1);
      return;
    end
    e = sb.pop_front();
    checkVal({e.tag, "_leds"}, 32'(ledsNow()), 32'(e.leds));
    checkVal({e.tag, "_hit"},  32'(hit_count), 32'(e.hit));
    checkVal({e.tag, "_near"}, 32'(near_count), 32'(e.near));
    checkVal({e.tag, "_all"},  32'(all_hit), 32'(e.all));
  endtask

  // Wait for the done pulse of the request just applied, checking latency and handshake
  task automatic runEval(string tag);
    int seen = 999;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) checkVal({tag, "_busy_scan"}, 32'(busy), 1);
      if (done) begin
        seen = n;
        break;
      end
    end
    checkVal({tag, "_latency"}, 32'(seen), 32'(LAT));
    if (seen != 999) begin
      checkVal({tag, "_busy_done"}, 32'(busy), 0);
      checkOutput();
      @(negedge clk);
      checkVal({tag, "_done_pulse"}, 32'(done), 0);
    end else begin
      void'(sb.pop_front());
    end
  endtask

  initial begin
    int dones;
    int first;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkVal("rst_busy", 32'(busy), 0);
    checkVal("rst_done", 32'(done), 0);
    checkVal("rst_leds", 32'(ledsNow()), 0);
    checkVal("rst_counts", 32'({hit_count, near_count, all_hit}), 0);

    // Main function under distinct patterns
    applyStimulus("exact", 20'h01234, 20'h01234, 10'h2AA, 3'd5, 3'd0);
    runEval("exact");
    applyStimulus("perm", 20'h01234, 20'h43210, 10'h165, 3'd1, 3'd4);
    runEval("perm");
    applyStimulus("disjoint", 20'h01234, 20'h56789, 10'h000, 3'd0, 3'd0);
    runEval("disjoint");
    applyStimulus("dup", 20'h01234, 20'h00000, 10'h255, 3'd1, 3'd4);
    runEval("dup");
    applyStimulus("invalid", 20'h01234, 20'h0123A, 10'h2AB, 3'd4, 3'd0);
    runEval("invalid");

    // Handshake: second start while busy ignored, guess change mid-scan ignored
    applyStimulus("hshake", 20'h01234, 20'h43210, 10'h165, 3'd1, 3'd4);
    dones = 0;
    first = 999;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start = (n == 3);
      if (n == 2) guess = 20'h99999;
      if (n == 2) checkVal("hold_leds", 32'(ledsNow()), 32'(10'h2AB));
      if (done) begin
        dones++;
        if (first == 999) begin
          first = n;
          checkOutput();
        end
      end
    end
    start = 1'b0;
    checkVal("hshake_latency", 32'(first), 32'(LAT));
    checkVal("hshake_done_count", 32'(dones), 1);
    checkVal("hshake_held", 32'(ledsNow()), 32'(10'h165));

    // Reset mid-scan aborts with no done
    @(negedge clk);
    secret = 20'h01234;
    guess  = 20'h01234;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done) dones++;
      rst = (n == RST_AT);
      if (n == RST_AT + 1) begin
        checkVal("abort_busy", 32'(busy), 0);
        checkVal("abort_leds", 32'(ledsNow()), 0);
        checkVal("abort_counts", 32'({hit_count, near_count, all_hit}), 0);
      end
    end
    rst = 1'b0;
    checkVal("abort_no_done", 32'(dones), 0);
    applyStimulus("after_abort", 20'h98765, 20'h98756, 10'h2A5, 3'd3, 3'd2);
    runEval("after_abort");

    // Reset and start together: reset wins
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    checkVal("rst_start_busy", 32'(busy), 0);
    checkVal("rst_start_leds", 32'(ledsNow()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wordle_feedback.md
Name: wordle_feedback

Overview:
- Downstream of the guess-entry/game-control stage.
- Consumes the settled 5-digit secret and each accepted 5-digit guess, both packed BCD.
- Computes the per-digit colour code that drives led0_in..led4_in, plus hit/near counts and an all-hit flag.
- Evaluation is sequential: one digit comparison per clock, with a start/busy/done handshake. Results are held until the next evaluation.

Parameters:
- DIGIT_W, 4, width of one BCD digit field.
- MAX_DIGIT, 9, largest legal digit value; any field above it is flagged invalid.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle request to evaluate the current guess
- secret  input  20  secret number; digit n is bits [4n+3:4n]
- guess  input  20  guess number, same packing
- busy  output  1  high while an evaluation is in progress
- done  output  1  one-cycle pulse when results become valid
- led0_in..led4_in  output  2 each  code for guess digit 0..4 (digit 0 = bits [3:0], the last digit entered)
- hit_count  output  3  number of digits with code 2'b10 (0..5)
- near_count  output  3  number of digits with code 2'b01 (0..5)
- all_hit  output  1  hit_count == 5

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, all ledN_in=2'b00, hit_count=0, near_count=0, all_hit=0. FSM goes to IDLE.
- Colour codes: 2'b00 miss; 2'b01 present in another position; 2'b10 correct position; 2'b11 invalid digit (>MAX_DIGIT).
- Code priority per guess digit g: invalid, then exact match (guess[g]==secret[g]), then present (guess[g]==secret[s] for any s!=g), else miss.
- Each guess digit is evaluated independently. A duplicate guess digit can therefore mark 01 twice; duplicates are rejected upstream.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - start=1 captures secret and guess into internal registers.
  - Clears the scratch codes and counts.
  - Sets g=0, s=0 and moves to SCAN. busy=1 from the next cycle.
- SCAN:
  - One (g,s) comparison per cycle. s counts 0..4; on s=4 it wraps to 0 and g increments.
  - The scratch code for g is updated per the priority rule.
  - Transitions to DONE after the (4,4) comparison: 25 SCAN cycles.
- DONE (one cycle):
  - Scratch codes are copied to ledN_in; hit_count, near_count and all_hit are updated.
  - done=1 and busy=0 in this same cycle, then return to IDLE.
- Latency: done is high in the 26th cycle after the cycle in which start was sampled.
- Output holding: outputs hold their values until the next DONE. They do not clear at start, so the LEDs keep the previous feedback during evaluation.
- start while busy (SCAN or DONE): ignored, no queueing.
- Input changes during SCAN: no effect, because the operands are captured at start.
- Reset mid-SCAN: aborts immediately, all outputs return to reset values, and no done is produced.
- Reset and start in the same cycle: reset wins.
- Counts are 3-bit and saturate naturally at 5; hit_count + near_count <= 5.

Optional Feature:
- Macro: WORDLE_FAST_EVAL_EN.
- When defined: SCAN compares guess digit g against all 5 secret digits in one cycle, so SCAN lasts 5 cycles and done appears in the 6th cycle after start.
- When undefined: the serial 25-cycle SCAN above.
- Codes, counts, handshake and reset behaviour are identical in both builds.

Test Plan:
- Exact match: secret=20'h01234, guess=20'h01234, start -> all ledN_in=2'b10, hit_count=5, near_count=0, all_hit=1, done exactly 26 cycles after start (6 with WORDLE_FAST_EVAL_EN).
- Permutation: secret=20'h01234, guess=20'h43210 -> led2_in=2'b10, led0/1/3/4_in=2'b01, hit_count=1, near_count=4, all_hit=0.
- Disjoint: secret=20'h01234, guess=20'h56789 -> all codes 2'b00, both counts 0.
- Invalid digit: secret=20'h01234, guess=20'h0123A -> led0_in=2'b11, led1..led4_in=2'b10, hit_count=4, near_count=0.
- Handshake: second start 3 cycles after the first while busy=1 -> ignored, exactly one done pulse; changing guess mid-SCAN leaves the result unchanged.
- Reset mid-scan: rst at cycle 10 of SCAN -> busy=0, all outputs at reset values, no done pulse; a fresh start then completes normally.
